// File: rtl/cusw_control_unit.sv
// cusw_control_unit: synth control unit - PLL/DAC startup sequencing, pot parameter banks and DAC volume
// Optional feature macro: POT_DEADBAND_EN (registers ignore pot changes of 2 LSB or less)
// Ports: clk50Mhz, RESET (async, active-high), locked (PLL lock);
//   P0A..P7A pot values and E0A..E7A level-sensitive bank enables from the Arduino link;
//   bank outputs Seq00, Osc*, ADSR*, Fltr*, Efct*, E*5, E*6 plus derived waveform/detune/filterSel/cuttoff;
//   SeqEnable/ADSREnable toggles; areset, CU_RESET, CU_RESET_N, DAC_RESET_out, DACpulseTrigger, readyFlag;
//   volume2DAC with its volchange strobe.
module cusw_control_unit #(
    parameter int         RST_HOLD_CYCLES = 16,
    parameter int         DAC_RST_CYCLES  = 32,
    parameter logic [9:0] POT_DEFAULT     = 10'h200
) (
    input  logic       clk50Mhz,
    input  logic       RESET,
    input  logic       locked,
    input  logic [9:0] P0A, P1A, P2A, P3A, P4A, P5A, P6A, P7A,
    input  logic       E0A, E1A, E2A, E3A, E4A, E5A, E6A, E7A,
    output logic [9:0] Seq00,
    output logic       SeqEnable,
    output logic [1:0] waveform,
    output logic [3:0] detune,
    output logic [9:0] Osc21, Osc31, Osc41, Osc51, Osc61,
    output logic       ADSREnable,
    output logic [9:0] ADSR02, ADSR12, ADSR32, ADSR42,
    output logic [1:0] filterSel,
    output logic [1:0] cuttoff,
    output logic [9:0] Fltr23, Fltr33, Fltr43, Fltr53, Fltr63,
    output logic [9:0] Efct04, Efct14, Efct24, Efct34, Efct44, Efct54, Efct64,
    output logic [9:0] E05, E15, E25, E35, E45, E55, E65,
    output logic [9:0] E06, E16, E26, E36, E46, E56, E66,
    output logic       areset,
    output logic       CU_RESET,
    output logic       CU_RESET_N,
    output logic [6:0] volume2DAC,
    output logic       volchange,
    output logic       DAC_RESET_out,
    output logic       DACpulseTrigger,
    output logic       readyFlag
);
    typedef enum logic [1:0] {WAIT_LOCK, HOLD, DAC_RST, READY} state_t;
    state_t      state;
    logic [15:0] cnt;
    logic [9:0]  p_r [0:7];
    logic [7:0]  e_r, e_d, sel;
    logic [9:0]  osc [2:6];
    logic [9:0]  adsr [0:3];
    logic [9:0]  fltr [2:6];
    logic [9:0]  efct [0:6];
    logic [9:0]  e5 [0:6];
    logic [9:0]  e6 [0:6];
    // last accepted source pot for each derived field, so the update gate has something to compare with
    logic [9:0]  wf_src, dt_src, fs_src, co_src, vol_src;
    logic [6:0]  vol_prev;
    logic        ready;

`ifdef POT_DEADBAND_EN
    function automatic logic upd(input logic [9:0] n, input logic [9:0] o);
        return (n > o) ? (n - o > 10'd2) : (o - n > 10'd2);
    endfunction
`else
    function automatic logic upd(input logic [9:0] n, input logic [9:0] o);
        return n != o;
    endfunction
`endif

    function automatic logic [1:0] cut_band(input logic [9:0] p);
        return (p < 10'd342) ? 2'd0 : (p < 10'd683) ? 2'd1 : 2'd2;
    endfunction

    assign areset     = RESET;
    assign CU_RESET_N = ~CU_RESET;
    assign ready      = state == READY;
    // isolate the lowest set enable: lowest index has priority
    assign sel        = e_r & (~e_r + 8'd1);

    assign {Osc21, Osc31, Osc41, Osc51, Osc61} = {osc[2], osc[3], osc[4], osc[5], osc[6]};
    assign {ADSR02, ADSR12, ADSR32, ADSR42} = {adsr[0], adsr[1], adsr[2], adsr[3]};
    assign {Fltr23, Fltr33, Fltr43, Fltr53, Fltr63} = {fltr[2], fltr[3], fltr[4], fltr[5], fltr[6]};
    assign {Efct04, Efct14, Efct24, Efct34, Efct44, Efct54, Efct64} =
        {efct[0], efct[1], efct[2], efct[3], efct[4], efct[5], efct[6]};
    assign {E05, E15, E25, E35, E45, E55, E65} = {e5[0], e5[1], e5[2], e5[3], e5[4], e5[5], e5[6]};
    assign {E06, E16, E26, E36, E46, E56, E66} = {e6[0], e6[1], e6[2], e6[3], e6[4], e6[5], e6[6]};

    always_ff @(posedge clk50Mhz or posedge RESET) begin
        if (RESET) begin
            state           <= WAIT_LOCK;
            cnt             <= '0;
            CU_RESET        <= 1'b1;
            DAC_RESET_out   <= 1'b0;
            DACpulseTrigger <= 1'b0;
            readyFlag       <= 1'b0;
        end else if (!locked) begin
            state           <= WAIT_LOCK;
            cnt             <= '0;
            CU_RESET        <= 1'b1;
            DAC_RESET_out   <= 1'b0;
            DACpulseTrigger <= 1'b0;
            readyFlag       <= 1'b0;
        end else begin
            DACpulseTrigger <= 1'b0;
            case (state)
                WAIT_LOCK: begin
                    state <= HOLD;
                    cnt   <= '0;
                end
                HOLD: begin
                    if (cnt == 16'(RST_HOLD_CYCLES - 1)) begin
                        state           <= DAC_RST;
                        cnt             <= '0;
                        CU_RESET        <= 1'b0;
                        DAC_RESET_out   <= 1'b1;
                        DACpulseTrigger <= 1'b1;
                    end else cnt <= cnt + 16'd1;
                end
                DAC_RST: begin
                    if (cnt == 16'(DAC_RST_CYCLES - 1)) begin
                        state         <= READY;
                        DAC_RESET_out <= 1'b0;
                        readyFlag     <= 1'b1;
                    end else cnt <= cnt + 16'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk50Mhz or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < 8; i++) p_r[i] <= '0;
            for (int i = 2; i < 7; i++) osc[i] <= POT_DEFAULT;
            for (int i = 0; i < 4; i++) adsr[i] <= POT_DEFAULT;
            for (int i = 2; i < 7; i++) fltr[i] <= POT_DEFAULT;
            for (int i = 0; i < 7; i++) begin
                efct[i] <= POT_DEFAULT;
                e5[i]   <= POT_DEFAULT;
                e6[i]   <= POT_DEFAULT;
            end
            e_r        <= '0;
            e_d        <= '0;
            Seq00      <= POT_DEFAULT;
            waveform   <= '0;
            detune     <= '0;
            filterSel  <= '0;
            cuttoff    <= '0;
            {wf_src, dt_src, fs_src, co_src, vol_src} <= '0;
            SeqEnable  <= 1'b0;
            ADSREnable <= 1'b0;
            volume2DAC <= '0;
            vol_prev   <= '0;
            volchange  <= 1'b0;
        end else begin
            {p_r[0], p_r[1], p_r[2], p_r[3]} <= {P0A, P1A, P2A, P3A};
            {p_r[4], p_r[5], p_r[6], p_r[7]} <= {P4A, P5A, P6A, P7A};
            e_r       <= {E7A, E6A, E5A, E4A, E3A, E2A, E1A, E0A};
            e_d       <= e_r;
            vol_prev  <= volume2DAC;
            volchange <= volume2DAC != vol_prev;
            if (ready) begin
                if (e_r[0] && !e_d[0]) SeqEnable <= ~SeqEnable;
                if (e_r[2] && !e_d[2]) ADSREnable <= ~ADSREnable;
                if (sel[0] && upd(p_r[0], Seq00)) Seq00 <= p_r[0];
                if (sel[1]) begin
                    if (upd(p_r[0], wf_src)) {wf_src, waveform} <= {p_r[0], p_r[0][9:8]};
                    if (upd(p_r[1], dt_src)) {dt_src, detune} <= {p_r[1], p_r[1][9:6]};
                    for (int i = 2; i < 7; i++) if (upd(p_r[i], osc[i])) osc[i] <= p_r[i];
                end
                if (sel[2]) for (int i = 0; i < 4; i++) if (upd(p_r[i], adsr[i])) adsr[i] <= p_r[i];
                if (sel[3]) begin
                    if (upd(p_r[0], fs_src)) {fs_src, filterSel} <= {p_r[0], p_r[0][9:8]};
                    if (upd(p_r[1], co_src)) {co_src, cuttoff} <= {p_r[1], cut_band(p_r[1])};
                    for (int i = 2; i < 7; i++) if (upd(p_r[i], fltr[i])) fltr[i] <= p_r[i];
                end
                if (sel[4]) for (int i = 0; i < 7; i++) if (upd(p_r[i], efct[i])) efct[i] <= p_r[i];
                if (sel[5]) for (int i = 0; i < 7; i++) if (upd(p_r[i], e5[i])) e5[i] <= p_r[i];
                if (sel[6]) for (int i = 0; i < 7; i++) if (upd(p_r[i], e6[i])) e6[i] <= p_r[i];
                if (sel[7] && upd(p_r[7], vol_src)) {vol_src, volume2DAC} <= {p_r[7], p_r[7][9:3]};
            end
        end
    end
endmodule

// File: tb/tb_cusw_control_unit.sv
// tb_cusw_control_unit: self-checking bench for cusw_control_unit
module tb_cusw_control_unit;
    localparam int SEQ = 0, SEN = 1, WF = 2, DT = 3, AEN = 4, FS = 5, CUT = 6, VOL = 7, VCH = 8;
    localparam int CUR = 9, CURN = 10, DACR = 11, TRIG = 12, RDY = 13, ARST = 14;
    localparam int OSC = 20, ADSR = 25, FLTR = 29, EFCT = 34, E5 = 41, E6 = 48;

    typedef struct {
        string       name;
        int          id;
        logic [31:0] exp;
    } exp_t;

    typedef struct {
        logic [9:0] p1;
        logic [9:0] p0;
        logic [1:0] cut;
        logic [1:0] fs;
    } vec_t;

    logic       clk = 1'b0, rst = 1'b1, locked = 1'b0;
    logic [9:0] p [8];
    logic [7:0] e;
    logic [9:0] seq;
    logic       seq_en, adsr_en, arst, cur, curn, vch, dacr, trig, rdy;
    logic [1:0] wf, fs, cut;
    logic [3:0] dt;
    logic [6:0] vol;
    logic [9:0] osc [5];
    logic [9:0] adsr [4];
    logic [9:0] fltr [5];
    logic [9:0] efct [7];
    logic [9:0] e5 [7];
    logic [9:0] e6 [7];

    exp_t       sb [$];
    logic [6:0] volq [$];
    vec_t       tbl [5];
    int         n_chk = 0, n_fail = 0, vcnt;

    cusw_control_unit dut (
        .clk50Mhz(clk), .RESET(rst), .locked(locked),
        .P0A(p[0]), .P1A(p[1]), .P2A(p[2]), .P3A(p[3]), .P4A(p[4]), .P5A(p[5]), .P6A(p[6]), .P7A(p[7]),
        .E0A(e[0]), .E1A(e[1]), .E2A(e[2]), .E3A(e[3]), .E4A(e[4]), .E5A(e[5]), .E6A(e[6]), .E7A(e[7]),
        .Seq00(seq), .SeqEnable(seq_en), .waveform(wf), .detune(dt),
        .Osc21(osc[0]), .Osc31(osc[1]), .Osc41(osc[2]), .Osc51(osc[3]), .Osc61(osc[4]),
        .ADSREnable(adsr_en), .ADSR02(adsr[0]), .ADSR12(adsr[1]), .ADSR32(adsr[2]), .ADSR42(adsr[3]),
        .filterSel(fs), .cuttoff(cut),
        .Fltr23(fltr[0]), .Fltr33(fltr[1]), .Fltr43(fltr[2]), .Fltr53(fltr[3]), .Fltr63(fltr[4]),
        .Efct04(efct[0]), .Efct14(efct[1]), .Efct24(efct[2]), .Efct34(efct[3]),
        .Efct44(efct[4]), .Efct54(efct[5]), .Efct64(efct[6]),
        .E05(e5[0]), .E15(e5[1]), .E25(e5[2]), .E35(e5[3]), .E45(e5[4]), .E55(e5[5]), .E65(e5[6]),
        .E06(e6[0]), .E16(e6[1]), .E26(e6[2]), .E36(e6[3]), .E46(e6[4]), .E56(e6[5]), .E66(e6[6]),
        .areset(arst), .CU_RESET(cur), .CU_RESET_N(curn), .volume2DAC(vol), .volchange(vch),
        .DAC_RESET_out(dacr), .DACpulseTrigger(trig), .readyFlag(rdy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [31:0] get(input int id);
        logic [31:0] r;
        r = 'x;
        case (id)
            SEQ:  r = 32'(seq);
            SEN:  r = 32'(seq_en);
            WF:   r = 32'(wf);
            DT:   r = 32'(dt);
            AEN:  r = 32'(adsr_en);
            FS:   r = 32'(fs);
            CUT:  r = 32'(cut);
            VOL:  r = 32'(vol);
            VCH:  r = 32'(vch);
            CUR:  r = 32'(cur);
            CURN: r = 32'(curn);
            DACR: r = 32'(dacr);
            TRIG: r = 32'(trig);
            RDY:  r = 32'(rdy);
            ARST: r = 32'(arst);
            default: ;
        endcase
        if (id >= OSC && id < OSC + 5) r = 32'(osc[id - OSC]);
        if (id >= ADSR && id < ADSR + 4) r = 32'(adsr[id - ADSR]);
        if (id >= FLTR && id < FLTR + 5) r = 32'(fltr[id - FLTR]);
        if (id >= EFCT && id < EFCT + 7) r = 32'(efct[id - EFCT]);
        if (id >= E5 && id < E5 + 7) r = 32'(e5[id - E5]);
        if (id >= E6 && id < E6 + 7) r = 32'(e6[id - E6]);
        return r;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic push(input string nm, input int id, input logic [31:0] exp);
        exp_t x;
        x.name = nm;
        x.id   = id;
        x.exp  = exp;
        sb.push_back(x);
    endtask

    task automatic push_n(input string nm, input int base, input int n, input logic [31:0] exp);
        for (int i = 0; i < n; i++) push($sformatf("%s%0d", nm, i), base + i, exp);
    endtask

    task automatic drain();
        exp_t x;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            chk(x.name, get(x.id), x.exp);
        end
    endtask

    task automatic startup();
        int n;
        locked = 1'b1;
        n = 0;
        while (cur && n < 100) begin
            tick();
            n++;
        end
        chk("cu_reset_hold", n, 17);
        chk("trig_on", 32'(trig), 1);
        chk("cu_reset_n_up", 32'(curn), 1);
        chk("not_ready_yet", 32'(rdy), 0);
        n = 0;
        while (dacr && n < 100) begin
            n++;
            tick();
            if (n == 1) chk("trig_len", 32'(trig), 0);
        end
        chk("dac_rst_len", n, 32);
        chk("ready_up", 32'(rdy), 1);
    endtask

    initial begin
        tbl[0] = '{10'd341, 10'd512, 2'd0, 2'd2};
        tbl[1] = '{10'd342, 10'd0, 2'd1, 2'd0};
        tbl[2] = '{10'd682, 10'd256, 2'd1, 2'd1};
        tbl[3] = '{10'd683, 10'd1023, 2'd2, 2'd3};
        tbl[4] = '{10'd1023, 10'd512, 2'd2, 2'd2};
        e = '0;
        for (int i = 0; i < 8; i++) p[i] = '0;
        tick(3);
        chk("areset_on", 32'(arst), 1);
        rst = 1'b0;
        tick(4);
        push("areset_off", ARST, 0);
        push("seq_rst", SEQ, 10'h200);
        push_n("osc_rst", OSC, 5, 10'h200);
        push_n("adsr_rst", ADSR, 4, 10'h200);
        push_n("fltr_rst", FLTR, 5, 10'h200);
        push_n("efct_rst", EFCT, 7, 10'h200);
        push_n("e5_rst", E5, 7, 10'h200);
        push_n("e6_rst", E6, 7, 10'h200);
        push("wf_rst", WF, 0);
        push("dt_rst", DT, 0);
        push("fs_rst", FS, 0);
        push("cut_rst", CUT, 0);
        push("sen_rst", SEN, 0);
        push("aen_rst", AEN, 0);
        push("vol_rst", VOL, 0);
        push("vch_rst", VCH, 0);
        push("cur_rst", CUR, 1);
        push("curn_rst", CURN, 0);
        push("dacr_rst", DACR, 0);
        push("trig_rst", TRIG, 0);
        push("rdy_rst", RDY, 0);
        drain();
        startup();
        e = 8'h02;
        for (int v = 0; v < 1024; v++) begin
            for (int i = 0; i < 7; i++) p[i] = 10'(v);
            tick();
        end
        tick(2);
        push("wf_max", WF, 3);
        push("dt_max", DT, 15);
        push_n("osc_max", OSC, 5, 1023);
        push("seq_keep", SEQ, 10'h200);
        push_n("adsr_keep", ADSR, 4, 10'h200);
        push_n("fltr_keep", FLTR, 5, 10'h200);
        push_n("efct_keep", EFCT, 7, 10'h200);
        push_n("e5_keep", E5, 7, 10'h200);
        push_n("e6_keep", E6, 7, 10'h200);
        drain();
        p[0] = 10'h100;
        p[1] = 10'h0c0;
        tick(2);
        push("wf_src", WF, 1);
        push("dt_src", DT, 3);
        drain();
        p[0] = 10'd1023;
        p[1] = 10'd1023;
        tick(2);
        e = 8'h00;
        tick();
        e = 8'h08;
        for (int r = 0; r < 5; r++) begin
            p[0] = tbl[r].p0;
            p[1] = tbl[r].p1;
            for (int i = 2; i < 7; i++) p[i] = tbl[r].p1 ^ 10'(i);
            tick(2);
            push($sformatf("cut_row%0d", r), CUT, 32'(tbl[r].cut));
            push($sformatf("fs_row%0d", r), FS, 32'(tbl[r].fs));
            for (int i = 2; i < 7; i++) push($sformatf("fltr_row%0d_%0d", r, i), FLTR + i - 2, 32'(tbl[4].p1 ^ 10'(i)) & 32'h0 | 32'(tbl[r].p1 ^ 10'(i)));
            drain();
        end
        e = 8'h00;
        tick();
        p[0] = 10'd100;
        p[1] = 10'd200;
        p[2] = 10'd300;
        p[3] = 10'd400;
        e = 8'h04;
        tick(2);
        push("aen_toggle", AEN, 1);
        push("adsr0", ADSR, 100);
        push("adsr1", ADSR + 1, 200);
        push("adsr3", ADSR + 2, 300);
        push("adsr4", ADSR + 3, 400);
        drain();
        p[4] = 10'd7;
        p[5] = 10'd8;
        p[6] = 10'd9;
        tick(2);
        push("adsr0_hold", ADSR, 100);
        push("adsr4_hold", ADSR + 3, 400);
        push_n("osc_ign", OSC, 5, 1023);
        for (int i = 2; i < 7; i++) push($sformatf("fltr_ign%0d", i), FLTR + i - 2, 32'(10'd1023 ^ 10'(i)));
        push_n("efct_ign", EFCT, 7, 10'h200);
        push("aen_steady", AEN, 1);
        drain();
        p[0] = 10'd777;
        e = 8'h05;
        tick(2);
        push("seq_prio", SEQ, 777);
        push("adsr0_prio", ADSR, 100);
        push("sen_toggle", SEN, 1);
        push("aen_prio", AEN, 1);
        drain();
        e = 8'h00;
        tick();
        e = 8'h80;
        tick(3);
        vcnt = 0;
        volq.delete();
        for (int v = 0; v < 1024; v++) begin
            p[7] = 10'(v);
            volq.push_back(7'(v >> 3));
            tick();
            if (vch) vcnt++;
            if (volq.size() == 2) chk("vol_track", 32'(vol), 32'(volq.pop_front()));
        end
        repeat (4) begin
            tick();
            if (vch) vcnt++;
        end
        chk("vol_pulses", vcnt, 127);
        chk("vol_max", 32'(vol), 127);
        p[7] = 10'd8;
        tick(5);
        vcnt = 0;
        for (int v = 9; v < 16; v++) begin
            p[7] = 10'(v);
            tick();
            if (vch) vcnt++;
        end
        repeat (3) begin
            tick();
            if (vch) vcnt++;
        end
        chk("vol_no_pulse", vcnt, 0);
        chk("vol_one", 32'(vol), 1);
        e = 8'h00;
        tick();
        locked = 1'b0;
        tick();
        chk("unlock_rdy", 32'(rdy), 0);
        chk("unlock_cur", 32'(cur), 1);
        chk("unlock_curn", 32'(curn), 0);
        p[0] = 10'd5;
        p[2] = 10'd5;
        e = 8'h02;
        tick(3);
        push("keep_seq", SEQ, 777);
        push("keep_wf", WF, 3);
        push_n("keep_osc", OSC, 5, 1023);
        push("keep_adsr0", ADSR, 100);
        push("keep_fltr0", FLTR, 32'(10'd1023 ^ 10'd2));
        push("keep_cut", CUT, 2);
        push("keep_vol", VOL, 1);
        drain();
        e = 8'h00;
        tick(2);
        startup();
        p[0] = 10'd321;
        e = 8'h01;
        tick(2);
        push("seq_relock", SEQ, 321);
        push("sen_relock", SEN, 0);
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/cusw_control_unit.md
Name: cusw_control_unit

Overview:
- Synth control unit.
- Captures eight 10-bit user potentiometer values (P0A..P7A, from the Arduino link) into per-module parameter banks, selected by module enable buttons E0A..E7A.
- Sequences startup: waits for PLL lock, holds downstream resets, then pulses the DAC reset and raises readyFlag.
- Drives the 7-bit DAC volume, with a change strobe.

Parameters:
- RST_HOLD_CYCLES, 16, cycles CU_RESET stays asserted after locked rises.
- DAC_RST_CYCLES, 32, width in cycles of DAC_RESET_out.
- POT_DEFAULT, 10'h200, reset value of every 10-bit bank register.

Ports:
- clk50Mhz input 1: sole clock; all logic on its rising edge.
- RESET input 1: asynchronous, active-high reset.
- locked input 1: PLL locked.
- P0A..P7A input 10 each: potentiometer values.
- E0A..E7A input 1 each: module enable buttons, level-sensitive.
- Seq00 output 10: sequencer clock rate.
- SeqEnable output 1: sequencer enable.
- waveform output 2; detune output 4.
- Osc21, Osc31, Osc41, Osc51, Osc61 output 10 each.
- ADSREnable output 1.
- ADSR02, ADSR12, ADSR32, ADSR42 output 10 each: attack, decay, sustain, release.
- filterSel output 2; cuttoff output 2.
- Fltr23..Fltr63 output 10 each.
- Efct04..Efct64 output 10 each (7 ports).
- E05..E65 output 10 each (7 ports).
- E06..E66 output 10 each (7 ports).
- areset output 1: PLL reset.
- CU_RESET output 1: downstream active-high reset.
- CU_RESET_N output 1: downstream active-low reset.
- volume2DAC output 7: DAC volume.
- volchange output 1: volume-change strobe.
- DAC_RESET_out output 1: DAC reset.
- DACpulseTrigger output 1: DAC restart trigger.
- readyFlag output 1: ready indication to the Arduino.

Behaviour:
- areset = RESET, combinational.
- Reset values:
  - All 10-bit bank outputs = POT_DEFAULT.
  - waveform = 0, detune = 0, filterSel = 0, cuttoff = 0.
  - SeqEnable = 0, ADSREnable = 0.
  - volume2DAC = 0, volchange = 0.
  - CU_RESET = 1, CU_RESET_N = 0.
  - DAC_RESET_out = 0, DACpulseTrigger = 0, readyFlag = 0.
- Startup FSM states:
  - WAIT_LOCK: CU_RESET = 1. Move to HOLD when locked = 1.
  - HOLD: CU_RESET = 1. After RST_HOLD_CYCLES cycles, release CU_RESET (CU_RESET_N is always its inverse). On entering DAC_RST, DACpulseTrigger = 1 for exactly one cycle.
  - DAC_RST: DAC_RESET_out = 1 for DAC_RST_CYCLES cycles, then move to READY.
  - READY: readyFlag = 1.
  - From any state, locked = 0 returns the FSM to WAIT_LOCK: CU_RESET reasserts and readyFlag clears. Bank contents are preserved.
- Bank capture runs only in READY.
- Inputs E*A and P*A are registered once before use (1-cycle latency). Each captured output updates 2 cycles after the input changes.
- If several enables are high at once, the lowest index wins and only that bank loads.
- Per-bank mapping while its enable is high, every cycle:
  - E0: Seq00 = P0.
  - E1: waveform = P0[9:8]; detune = P1[9:6]; Osc21..Osc61 = P2..P6.
  - E2: ADSR02 = P0; ADSR12 = P1; ADSR32 = P2; ADSR42 = P3. P4..P6 are ignored.
  - E3: filterSel = P0[9:8]; cuttoff = 0 if P1 < 342, 1 if P1 < 683, else 2 (never 3); Fltr23..Fltr63 = P2..P6.
  - E4: Efct04..Efct64 = P0..P6.
  - E5: E05..E65 = P0..P6.
  - E6: E06..E66 = P0..P6.
  - E7: volume2DAC = P7[9:3]. P0..P6 are ignored.
- SeqEnable toggles on each registered rising edge of E0A. ADSREnable toggles on each registered rising edge of E2A. Edges are detected only in READY.
- volchange: one-cycle pulse in the cycle after volume2DAC takes a new value. No pulse when the value is rewritten unchanged.
- Banks not selected hold their values indefinitely.

Optional Feature:
- Macro POT_DEADBAND_EN.
- Defined: a selected 10-bit register (and volume2DAC source) updates only when the registered pot differs from the stored value by more than 2 LSB.
- Defined, derived fields (waveform, detune, filterSel, cuttoff) use the same gate on their source pot.
- Undefined: registers update on any difference.

Test Plan:
- Reset and lock:
  - RESET=1, then RESET=0 with locked=0: all outputs at reset values, CU_RESET=1 held, readyFlag=0.
  - Raise locked: CU_RESET falls after 16 cycles, then DACpulseTrigger pulses for 1 cycle, DAC_RESET_out is high for 32 cycles, then readyFlag=1.
- E1A=1, sweep P0..P6 from 0 to 1023:
  - At P=1023: waveform=3, detune=15, Osc21..Osc61=1023.
  - Seq00, ADSR*, Fltr* and other banks unchanged at 10'h200.
- E3A=1, P1 = 341 / 342 / 682 / 683 / 1023: cuttoff = 0 / 1 / 1 / 2 / 2. P0=512 gives filterSel=2.
- E2A pulse: ADSREnable toggles 0→1. P4..P6 changes alter no output. E0A=1 with E2A=1: only Seq00 loads.
- E7A=1, sweep P7 from 0 to 1023:
  - volume2DAC steps 0..127.
  - Exactly 127 volchange pulses.
  - P7 moving 8→15 gives no pulse.
- After READY, drop locked:
  - readyFlag=0, CU_RESET=1.
  - Banks retain values.
  - Re-lock repeats the startup sequence.
